// File: rtl/seq_cla_adder_pkg.sv
// Shared constants and state encoding for the nibble-serial carry-lookahead adder.
package seq_cla_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/seq_cla_adder_nibble_cla.sv
// Combinational 4-bit carry-lookahead slice: per-bit propagate/generate
// followed by two-level carry equations for every internal carry.
module nibble_cla
  import seq_cla_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum4,
  output logic                c3,
  output logic                cout
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic                c1;
  logic                c2;

  assign p = a4 ^ b4;
  assign g = a4 & b4;

  // Every carry is a flat sum of products of cin, so none waits on another.
  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum4 = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/seq_cla_adder.sv
// Sequential adder/subtractor that handles one nibble per clock through a
// single lookahead slice, carrying between nibbles in a register.
module seq_cla_adder
  import seq_cla_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         sub,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLE_W*NIBBLES-1:0]  result,
  output logic                         cout,
  output logic                         ovf,
  output logic                         zero
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t              state;
  state_t              next_state;
  logic [W-1:0]        op_a;
  logic [W-1:0]        op_b;
  logic                carry_reg;
  logic [IW-1:0]       idx;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] sum_nib;
  logic                c3_nib;
  logic                cout_nib;
  logic                last;

  // Select the operand nibble addressed by the index counter.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_nib = op_a[i*NIBBLE_W +: NIBBLE_W];
        b_nib = op_b[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  assign last = (idx == IW'(NIBBLES - 1));

  nibble_cla u_nibble_cla (
    .a4   (a_nib),
    .b4   (b_nib),
    .cin  (carry_reg),
    .sum4 (sum_nib),
    .c3   (c3_nib),
    .cout (cout_nib)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (last)  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted at capture and the +1 rides in
  // as the initial carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a      <= a;
            op_b      <= sub ? ~b : b;
            carry_reg <= sub;
            idx       <= '0;
          end
        end
        CALC: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) result[i*NIBBLE_W +: NIBBLE_W] <= sum_nib;
          end
          carry_reg <= cout_nib;
          if (last) begin
            idx  <= '0;
            cout <= cout_nib;
            ovf  <= c3_nib ^ cout_nib;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign zero = (result == '0);

endmodule

// File: tb/tb_seq_cla_adder.sv
// Directed self-checking bench for seq_cla_adder: an arithmetic reference
// model checked every cycle, plus hand-computed literal results per vector.
module tb_seq_cla_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  int total = 0;
  int bad   = 0;
  bit checking = 0;

  int           m_busy_left = 0;
  logic [W-1:0] pend_result = '0;
  logic         pend_cout = 1'b0;
  logic         pend_ovf = 1'b0;
  logic [W-1:0] exp_result = '0;
  logic         exp_cout = 1'b0;
  logic         exp_ovf = 1'b0;

  seq_cla_adder #(.NIBBLES(NIBBLES)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference arithmetic on plain integers: unsigned for result/carry,
  // signed range test for overflow.
  task automatic model_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(ia);
    ub = int'(ib);
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    ur = isub ? (ua - ub) : (ua + ub);
    sr = isub ? (sa - sb) : (sa + sb);
    pend_result = W'(ur);
    pend_cout   = isub ? (ua >= ub) : (ur >= (1 << W));
    pend_ovf    = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_busy_left = 0;
      exp_result  = '0;
      exp_cout    = 1'b0;
      exp_ovf     = 1'b0;
    end else if (m_busy_left == 0) begin
      if (start) begin
        model_op(a, b, sub);
        m_busy_left = NIBBLES + 1;
      end
    end else begin
      m_busy_left--;
      if (m_busy_left == 1) begin
        exp_result = pend_result;
        exp_cout   = pend_cout;
        exp_ovf    = pend_ovf;
      end
    end
  end

  // Result flags are only meaningful once the operation has finished.
  always @(negedge clk) begin
    if (checking) begin
      compare("busy", W'(busy), W'(m_busy_left > 0));
      compare("done", W'(done), W'(m_busy_left == 1));
      if (m_busy_left <= 1) begin
        compare("model_result", result, exp_result);
        compare("model_cout", W'(cout), W'(exp_cout));
        compare("model_ovf", W'(ovf), W'(exp_ovf));
        compare("model_zero", W'(zero), W'(exp_result == '0));
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
    @(negedge clk);
    a     = ia;
    b     = ib;
    sub   = isub;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    sub   = 1'($urandom);
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] e_res, input logic e_cout,
                             input logic e_ovf, input logic e_zero);
    compare({name, "_result"}, result, e_res);
    compare({name, "_cout"}, W'(cout), W'(e_cout));
    compare({name, "_ovf"}, W'(ovf), W'(e_ovf));
    compare({name, "_zero"}, W'(zero), W'(e_zero));
  endtask

  task automatic runOp(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic isub, input logic [W-1:0] e_res, input logic e_cout,
                       input logic e_ovf, input logic e_zero);
    int n;
    applyStimulus(ia, ib, isub);
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    compare({name, "_latency"}, W'(n), W'(NIBBLES + 1));
    checkOutput(name, e_res, e_cout, e_ovf, e_zero);
    compare({name, "_model_pin"}, pend_result, e_res);
    repeat (3) @(negedge clk);
    checkOutput({name, "_hold"}, e_res, e_cout, e_ovf, e_zero);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int cnt;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checking = 1;
    checkOutput("reset", 16'h0000, 1'b0, 1'b0, 1'b1);
    compare("reset_busy", W'(busy), W'(0));
    compare("reset_done", W'(done), W'(0));

    runOp("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    runOp("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    runOp("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    runOp("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    runOp("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    runOp("sub_self", 16'hA5C3, 16'hA5C3, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    // A start pulse in the middle of an operation must be dropped.
    applyStimulus(16'h0001, 16'h0001, 1'b0);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) begin
        a     = 16'hAAAA;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) cnt++;
      @(negedge clk);
    end
    compare("ignore_start_done_count", W'(cnt), W'(1));
    checkOutput("ignore_start", 16'h0002, 1'b0, 1'b0, 1'b0);

    // Reset on the second CALC cycle aborts the operation silently.
    applyStimulus(16'h00FF, 16'h0F0F, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort", 16'h0000, 1'b0, 1'b0, 1'b1);
    compare("abort_busy", W'(busy), W'(0));
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) cnt++;
      @(negedge clk);
    end
    compare("abort_no_done", W'(cnt), W'(0));

    runOp("after_abort", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);

    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
